// File: rtl/ara_eoc_pkg.sv
// Shared types and exit-word helpers for the Ara end-of-computation monitor.
package ara_eoc_pkg;

  localparam int unsigned ExitMaxW = 64;
  localparam int unsigned CodeMaxW = ExitMaxW - 1;

  typedef enum logic [1:0] {
    EocIdle,
    EocRun,
    EocDone
  } eoc_state_e;

  typedef struct packed {
    logic                captured;
    logic [CodeMaxW-1:0] code;
  } eoc_chan_t;

  // Valid flag of a tohost-style exit word.
  function automatic logic exit_valid(input logic [ExitMaxW-1:0] word);
    return word[0];
  endfunction

  // Exit code carried above the valid flag.
  function automatic logic [CodeMaxW-1:0] exit_code(input logic [ExitMaxW-1:0] word);
    return word[ExitMaxW-1:1];
  endfunction

endpackage

// File: rtl/ara_eoc_monitor_if.sv
// Exit-word / status bundle between the testharness exits and the EOC monitor.
interface ara_eoc_monitor_if #(
  parameter int unsigned NrChannels = 4,
  parameter int unsigned ExitWidth  = 64,
  parameter int unsigned CntWidth   = 64
);
  localparam int unsigned FailW = (NrChannels > 1) ? $clog2(NrChannels) : 1;

  logic                             start_i;
  logic [NrChannels-1:0]            chan_en_i;
  logic [NrChannels*ExitWidth-1:0]  exit_i;
  logic [NrChannels-1:0]            chan_done_o;
  logic                             done_o;
  logic                             fail_o;
  logic                             timeout_o;
  logic [FailW-1:0]                 fail_chan_o;
  logic [ExitWidth-2:0]             exit_code_o;
  logic [CntWidth-1:0]              cycles_o;

  modport master (
    output start_i, chan_en_i, exit_i,
    input  chan_done_o, done_o, fail_o, timeout_o, fail_chan_o, exit_code_o, cycles_o
  );

  modport slave (
    input  start_i, chan_en_i, exit_i,
    output chan_done_o, done_o, fail_o, timeout_o, fail_chan_o, exit_code_o, cycles_o
  );

endinterface

// File: rtl/ara_eoc_chan.sv
// Sticky first-exit capture register for one monitored channel.
module ara_eoc_chan
  import ara_eoc_pkg::*;
#(
  parameter int unsigned CodeW = CodeMaxW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             valid_i,
  input  logic [CodeW-1:0] code_i,
  output logic             captured_o,
  output logic [CodeW-1:0] code_o,
  output logic             hit_c_o,
  output logic             is_fail_c_o
);

  eoc_chan_t chan_q, chan_d;

  // This edge captures: enabled, valid and nothing held yet.
  assign hit_c_o     = enable_i && valid_i && !chan_q.captured;
  assign is_fail_c_o = hit_c_o && (code_i != '0);

  // First capture wins; clear restarts the channel.
  always_comb begin
    chan_d = chan_q;
    if (clear_i) begin
      chan_d = '0;
    end else if (hit_c_o) begin
      chan_d.captured = 1'b1;
      chan_d.code     = CodeMaxW'(code_i);
    end
  end

  // Capture state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) chan_q <= '0;
    else       chan_q <= chan_d;
  end

  assign captured_o = chan_q.captured;
  assign code_o     = CodeW'(chan_q.code);

endmodule

// File: rtl/ara_eoc_monitor.sv
// End-of-computation monitor: per-channel exit capture, runtime counter,
// lowest-index fail reporting. Optional watchdog under ARA_EOC_TIMEOUT_EN.
module ara_eoc_monitor
  import ara_eoc_pkg::*;
#(
  parameter int unsigned NrChannels    = 4,
  parameter int unsigned ExitWidth     = 64,
  parameter int unsigned CntWidth      = 64,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input logic               clk_i,
  input logic               rst_i,
  ara_eoc_monitor_if.slave  bus
);

  localparam int unsigned CodeW = ExitWidth - 1;
  localparam int unsigned FailW = (NrChannels > 1) ? $clog2(NrChannels) : 1;

  eoc_state_e            state_q;
  logic [CntWidth-1:0]   cnt_q, cnt_inc;
  logic [NrChannels-1:0] en_q;
  logic                  done_q, fail_q, timeout_q;
  logic [FailW-1:0]      fail_chan_q, fail_idx;

  logic [NrChannels-1:0] captured, hit, hit_fail, captured_nxt;
  logic [CodeW-1:0]      chan_code [NrChannels];
  logic                  start_ok, in_run, all_done;

  // Lowest set bit index of a channel vector (0 if none).
  function automatic logic [FailW-1:0] lowest_idx(input logic [NrChannels-1:0] v);
    logic [FailW-1:0] idx;
    idx = '0;
    for (int i = int'(NrChannels) - 1; i >= 0; i--) begin
      if (v[i]) idx = FailW'(i);
    end
    return idx;
  endfunction

  assign in_run   = (state_q == EocRun);
  assign start_ok = (state_q != EocRun) && bus.start_i;

  // One sticky capture slot per channel.
  for (genvar g = 0; g < NrChannels; g++) begin : g_chan
    logic [ExitWidth-1:0] word;
    assign word = bus.exit_i[g*ExitWidth +: ExitWidth];

    ara_eoc_chan #(.CodeW(CodeW)) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (start_ok),
      .enable_i    (in_run && en_q[g]),
      .valid_i     (exit_valid(ExitMaxW'(word))),
      .code_i      (CodeW'(exit_code(ExitMaxW'(word)))),
      .captured_o  (captured[g]),
      .code_o      (chan_code[g]),
      .hit_c_o     (hit[g]),
      .is_fail_c_o (hit_fail[g])
    );
  end

  // Termination view including exits sampled on this edge.
  assign captured_nxt = captured | hit;
  assign all_done     = &(captured_nxt | ~en_q);
  assign fail_idx     = lowest_idx(hit_fail);
  assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);

`ifdef ARA_EOC_TIMEOUT_EN
  logic             wdog_hit;
  logic [FailW-1:0] pend_idx;
  assign wdog_hit = (cnt_inc >= CntWidth'(TimeoutCycles));
  assign pend_idx = lowest_idx(en_q & ~captured_nxt);
`else
  // Watchdog compiled out: the limit has no consumer.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^CntWidth'(TimeoutCycles);
`endif

  // Run-control FSM with counter and registered status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EocIdle;
      cnt_q       <= '0;
      en_q        <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_chan_q <= '0;
    end else begin
      case (state_q)
        EocIdle, EocDone: begin
          if (bus.start_i) begin
            state_q     <= EocRun;
            cnt_q       <= '0;
            en_q        <= bus.chan_en_i;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_chan_q <= '0;
          end
        end
        EocRun: begin
          cnt_q <= cnt_inc;
          if (|hit_fail) begin
            state_q     <= EocDone;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_chan_q <= fail_idx;
          end else if (all_done) begin
            state_q <= EocDone;
            done_q  <= 1'b1;
`ifdef ARA_EOC_TIMEOUT_EN
          end else if (wdog_hit) begin
            state_q     <= EocDone;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            timeout_q   <= 1'b1;
            fail_chan_q <= pend_idx;
`endif
          end
        end
        default: state_q <= EocIdle;
      endcase
    end
  end

  assign bus.chan_done_o = captured;
  assign bus.done_o      = done_q;
  assign bus.fail_o      = fail_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.fail_chan_o = fail_chan_q;
  // Reported channel holds its own captured code; pass and timeout select a zero code.
  assign bus.exit_code_o = chan_code[fail_chan_q];
  assign bus.cycles_o    = cnt_q;

endmodule

// File: tb/tb_ara_eoc_monitor.sv
// Directed bench for ara_eoc_monitor (watchdog scenario only with ARA_EOC_TIMEOUT_EN).
module tb_ara_eoc_monitor;

  localparam int unsigned NrCh  = 4;
  localparam int unsigned ExitW = 64;
  localparam int unsigned CntW  = 64;
  localparam int unsigned Tmo   = 20;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ara_eoc_monitor_if #(.NrChannels(NrCh), .ExitWidth(ExitW), .CntWidth(CntW)) bus ();

  ara_eoc_monitor #(
    .NrChannels(NrCh), .ExitWidth(ExitW), .CntWidth(CntW), .TimeoutCycles(Tmo)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exit(input int ch, input logic [63:0] w);
    bus.exit_i[ch*ExitW +: ExitW] = w;
  endtask

  // Start pulse sampled on the next edge (edge 0 of the run).
  task automatic start_run(input logic [3:0] mask);
    bus.chan_en_i = mask;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.chan_en_i = '0;
    bus.exit_i = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", bus.done_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL rst_fail got %0b want 0", bus.fail_o); end
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b want 0", bus.timeout_o); end
    checks++; if (bus.chan_done_o !== 4'b0000) begin errors++; $display("FAIL rst_chan_done got %b want 0000", bus.chan_done_o); end
    checks++; if (bus.cycles_o !== 64'd0) begin errors++; $display("FAIL rst_cycles got %0d want 0", bus.cycles_o); end
    checks++; if (bus.exit_code_o !== 63'd0) begin errors++; $display("FAIL rst_code got %0d want 0", bus.exit_code_o); end
  endtask

  task automatic test_idle_ignored();
    set_exit(0, 64'h1); set_exit(1, 64'h7); set_exit(2, 64'h1); set_exit(3, 64'h5);
    tick(); tick(); tick();
    checks++; if (bus.chan_done_o !== 4'b0000) begin errors++; $display("FAIL idle_chan_done got %b want 0000", bus.chan_done_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL idle_done got %0b want 0", bus.done_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL idle_fail got %0b want 0", bus.fail_o); end
    bus.exit_i = '0;
  endtask

  task automatic test_all_pass();
    bus.exit_i = '0;
    start_run(4'b1111);
    for (int e = 1; e <= 9; e++) begin
      if (e == 3) set_exit(0, 64'h1);
      if (e == 5) set_exit(1, 64'h1);
      if (e == 7) set_exit(2, 64'h1);
      if (e == 9) set_exit(3, 64'h1);
      tick();
      if (e == 8) begin
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL pass_early_done got %0b want 0", bus.done_o); end
        checks++; if (bus.chan_done_o !== 4'b0111) begin errors++; $display("FAIL pass_partial got %b want 0111", bus.chan_done_o); end
      end
    end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL pass_done got %0b want 1", bus.done_o); end
    checks++; if (bus.cycles_o !== 64'd9) begin errors++; $display("FAIL pass_cycles got %0d want 9", bus.cycles_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL pass_fail got %0b want 0", bus.fail_o); end
    checks++; if (bus.exit_code_o !== 63'd0) begin errors++; $display("FAIL pass_code got %0d want 0", bus.exit_code_o); end
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL pass_timeout got %0b want 0", bus.timeout_o); end
    checks++; if (bus.chan_done_o !== 4'b1111) begin errors++; $display("FAIL pass_chan_done got %b want 1111", bus.chan_done_o); end
    tick(); tick(); tick();
    checks++; if (bus.cycles_o !== 64'd9) begin errors++; $display("FAIL pass_frozen got %0d want 9", bus.cycles_o); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL pass_sticky got %0b want 1", bus.done_o); end
  endtask

  task automatic test_fail_abort();
    bus.exit_i = '0;
    start_run(4'b1111);
    for (int e = 1; e <= 4; e++) begin
      if (e == 4) set_exit(2, 64'h7);
      tick();
    end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL abort_done got %0b want 1", bus.done_o); end
    checks++; if (bus.fail_o !== 1'b1) begin errors++; $display("FAIL abort_fail got %0b want 1", bus.fail_o); end
    checks++; if (bus.fail_chan_o !== 2'd2) begin errors++; $display("FAIL abort_chan got %0d want 2", bus.fail_chan_o); end
    checks++; if (bus.exit_code_o !== 63'd3) begin errors++; $display("FAIL abort_code got %0d want 3", bus.exit_code_o); end
    checks++; if (bus.chan_done_o !== 4'b0100) begin errors++; $display("FAIL abort_chan_done got %b want 0100", bus.chan_done_o); end
    checks++; if (bus.cycles_o !== 64'd4) begin errors++; $display("FAIL abort_cycles got %0d want 4", bus.cycles_o); end
  endtask

  task automatic test_multi_fail();
    bus.exit_i = '0;
    start_run(4'b1111);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL restart_done got %0b want 0", bus.done_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL restart_fail got %0b want 0", bus.fail_o); end
    checks++; if (bus.chan_done_o !== 4'b0000) begin errors++; $display("FAIL restart_chan_done got %b want 0000", bus.chan_done_o); end
    checks++; if (bus.cycles_o !== 64'd0) begin errors++; $display("FAIL restart_cycles got %0d want 0", bus.cycles_o); end
    checks++; if (bus.exit_code_o !== 63'd0) begin errors++; $display("FAIL restart_code got %0d want 0", bus.exit_code_o); end
    for (int e = 1; e <= 2; e++) begin
      if (e == 2) begin
        set_exit(1, 64'd11);
        set_exit(3, 64'd5);
      end
      tick();
    end
    checks++; if (bus.fail_chan_o !== 2'd1) begin errors++; $display("FAIL multi_chan got %0d want 1", bus.fail_chan_o); end
    checks++; if (bus.exit_code_o !== 63'd5) begin errors++; $display("FAIL multi_code got %0d want 5", bus.exit_code_o); end
    checks++; if (bus.chan_done_o !== 4'b1010) begin errors++; $display("FAIL multi_chan_done got %b want 1010", bus.chan_done_o); end
    checks++; if (bus.cycles_o !== 64'd2) begin errors++; $display("FAIL multi_cycles got %0d want 2", bus.cycles_o); end
  endtask

  task automatic test_mask();
    bus.exit_i = '0;
    start_run(4'b0011);
    for (int e = 1; e <= 6; e++) begin
      if (e == 2) begin
        set_exit(2, 64'h7);
        set_exit(3, 64'h1);
        set_exit(0, 64'h1);
      end
      if (e == 3) bus.start_i = 1'b1;
      if (e == 4) set_exit(0, 64'h7);
      if (e == 6) set_exit(1, 64'h1);
      tick();
      bus.start_i = 1'b0;
      if (e == 5) begin
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL mask_early_done got %0b want 0", bus.done_o); end
        checks++; if (bus.chan_done_o !== 4'b0001) begin errors++; $display("FAIL mask_partial got %b want 0001", bus.chan_done_o); end
      end
    end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL mask_done got %0b want 1", bus.done_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL mask_fail got %0b want 0", bus.fail_o); end
    checks++; if (bus.chan_done_o !== 4'b0011) begin errors++; $display("FAIL mask_chan_done got %b want 0011", bus.chan_done_o); end
    checks++; if (bus.cycles_o !== 64'd6) begin errors++; $display("FAIL mask_cycles got %0d want 6", bus.cycles_o); end
    checks++; if (bus.exit_code_o !== 63'd0) begin errors++; $display("FAIL mask_code got %0d want 0", bus.exit_code_o); end
  endtask

  task automatic test_empty_mask();
    bus.exit_i = '0;
    start_run(4'b0000);
    tick();
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL empty_done got %0b want 1", bus.done_o); end
    checks++; if (bus.cycles_o !== 64'd1) begin errors++; $display("FAIL empty_cycles got %0d want 1", bus.cycles_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL empty_fail got %0b want 0", bus.fail_o); end
  endtask

`ifdef ARA_EOC_TIMEOUT_EN
  task automatic test_timeout();
    bus.exit_i = '0;
    start_run(4'b0001);
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 19) begin
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL wdog_early got %0b want 0", bus.done_o); end
      end
    end
    checks++; if (bus.timeout_o !== 1'b1) begin errors++; $display("FAIL wdog_timeout got %0b want 1", bus.timeout_o); end
    checks++; if (bus.fail_o !== 1'b1) begin errors++; $display("FAIL wdog_fail got %0b want 1", bus.fail_o); end
    checks++; if (bus.cycles_o !== 64'd20) begin errors++; $display("FAIL wdog_cycles got %0d want 20", bus.cycles_o); end
    checks++; if (bus.exit_code_o !== 63'd0) begin errors++; $display("FAIL wdog_code got %0d want 0", bus.exit_code_o); end
    checks++; if (bus.fail_chan_o !== 2'd0) begin errors++; $display("FAIL wdog_chan got %0d want 0", bus.fail_chan_o); end
    bus.exit_i = '0;
    start_run(4'b0001);
    for (int e = 1; e <= 20; e++) begin
      if (e == 20) set_exit(0, 64'h1);
      tick();
    end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL race_done got %0b want 1", bus.done_o); end
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL race_timeout got %0b want 0", bus.timeout_o); end
    checks++; if (bus.fail_o !== 1'b0) begin errors++; $display("FAIL race_fail got %0b want 0", bus.fail_o); end
  endtask
`endif

  task automatic test_reset_mid_run();
    bus.exit_i = '0;
    start_run(4'b1111);
    for (int e = 1; e <= 4; e++) begin
      if (e == 2) set_exit(0, 64'h1);
      tick();
    end
    checks++; if (bus.chan_done_o !== 4'b0001) begin errors++; $display("FAIL mid_chan_done got %b want 0001", bus.chan_done_o); end
    checks++; if (bus.cycles_o !== 64'd4) begin errors++; $display("FAIL mid_cycles got %0d want 4", bus.cycles_o); end
    rst = 1'b1;
    tick();
    checks++; if (bus.chan_done_o !== 4'b0000) begin errors++; $display("FAIL midrst_chan_done got %b want 0000", bus.chan_done_o); end
    checks++; if (bus.cycles_o !== 64'd0) begin errors++; $display("FAIL midrst_cycles got %0d want 0", bus.cycles_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b want 0", bus.done_o); end
    rst = 1'b0;
    bus.exit_i = '0;
    tick();
    start_run(4'b1111);
    for (int e = 1; e <= 3; e++) begin
      if (e == 3) bus.exit_i = {4{64'h1}};
      tick();
    end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL rerun_done got %0b want 1", bus.done_o); end
    checks++; if (bus.cycles_o !== 64'd3) begin errors++; $display("FAIL rerun_cycles got %0d want 3", bus.cycles_o); end
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_all_pass();
    test_fail_abort();
    test_multi_fail();
    test_mask();
    test_empty_mask();
`ifdef ARA_EOC_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
